// File: rtl/sysarr_feeder_pkg.sv
// Shared definitions for the systolic-array feeder: default sizes, FSM states and FP constants.
package sysarr_feeder_pkg;

  localparam int unsigned NDef  = 4;
  localparam int unsigned DwDef = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3f80_0000;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StDone
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sysarr_feeder_skew_sel.sv
// Combinational wavefront selector: picks the diagonally skewed A/B elements for step t.
module sysarr_feeder_skew_sel #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 3
) (
  input  logic [N*N*DW-1:0] buf_a,
  input  logic [N*N*DW-1:0] buf_b,
  input  logic [TW-1:0]     t,
  output logic [N*DW-1:0]   l_nxt,
  output logic [N*DW-1:0]   u_nxt
);

  // Both buffers are flattened row-major: element [r][c] sits at DW*(r*N+c).
  always_comb begin
    int k;
    l_nxt = '0;
    u_nxt = '0;
    k     = 0;
    for (int i = 0; i < int'(N); i++) begin
      k = int'(t) - i;
      if (k >= 0 && k < int'(N)) begin
        l_nxt[DW*i +: DW] = buf_a[DW*(i*int'(N) + k) +: DW];
        u_nxt[DW*i +: DW] = buf_b[DW*(k*int'(N) + i) +: DW];
      end
    end
  end

endmodule

// File: rtl/sysarr_feeder.sv
// Loads A rows / B columns over valid/ready, then clears, streams the skewed wavefront into the
// systolic array, waits out the drain latency and pulses done.
module sysarr_feeder
  import sysarr_feeder_pkg::*;
#(
  parameter int unsigned N         = NDef,
  parameter int unsigned DW        = DwDef,
  parameter int unsigned DRAIN_CYC = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic            sa_clr,
  output logic [N*DW-1:0] l_bus,
  output logic [N*DW-1:0] u_bus,
  output logic            busy,
  output logic            done
);

  localparam int unsigned StreamCyc = 2 * N - 1;
  localparam int unsigned BW        = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW        = $clog2(max_u(StreamCyc, DRAIN_CYC) + 1);

  state_e              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N*N*DW-1:0]   buf_a_q, buf_a_d;
  logic [N*N*DW-1:0]   buf_b_q, buf_b_d;

  logic                sa_clr_q, sa_clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N*DW-1:0]     l_bus_q, l_bus_d;
  logic [N*DW-1:0]     u_bus_q, u_bus_d;
  logic [N*DW-1:0]     skew_l, skew_u;

  assign in_ready = (state_q == StIdle);
  assign sa_clr   = sa_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign l_bus    = l_bus_q;
  assign u_bus    = u_bus_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      cnt_q    <= '0;
      buf_a_q  <= '0;
      buf_b_q  <= '0;
      sa_clr_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      l_bus_q  <= '0;
      u_bus_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      buf_a_q  <= buf_a_d;
      buf_b_q  <= buf_b_d;
      sa_clr_q <= sa_clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      l_bus_q  <= l_bus_d;
      u_bus_q  <= u_bus_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Beat k carries row k of A and column k of B.
          for (int i = 0; i < int'(N); i++) begin
            buf_a_d[DW*(int'(beat_q)*int'(N) + i) +: DW] = in_a[DW*i +: DW];
            buf_b_d[DW*(i*int'(N) + int'(beat_q)) +: DW] = in_b[DW*i +: DW];
          end
          if (beat_q == BW'(N - 1)) begin
            state_d = StClear;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StClear: begin
        state_d = StStream;
        cnt_d   = '0;
      end
      StStream: begin
        if (cnt_q == CW'(StreamCyc - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  sysarr_feeder_skew_sel #(
    .N  (N),
    .DW (DW),
    .TW (CW)
  ) u_skew_sel (
    .buf_a (buf_a_d),
    .buf_b (buf_b_d),
    .t     (cnt_d),
    .l_nxt (skew_l),
    .u_nxt (skew_u)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    sa_clr_d = (state_d == StClear);
    busy_d   = (state_d == StClear) || (state_d == StStream) || (state_d == StDrain);
    done_d   = (state_d == StDone);
    l_bus_d  = '0;
    u_bus_d  = '0;
    if (state_d == StStream) begin
      l_bus_d = skew_l;
      u_bus_d = skew_u;
    end
  end

endmodule
